// File: rtl/striping.sv
// -----------------------------------------------------------------------------
// striping
//   Splits a serial word stream across two output lanes. When lane1_en is
//   high, consecutive valid words alternate between lane 0 and lane 1. Any gap
//   in valid_in re-aligns the stream, so the next word starts again on lane 0.
//   When lane1_en is low, all traffic goes to lane 0. Lane outputs are
//   registered with one cycle of latency. Each lane has a wrapping word counter.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   data_in      [WIDTH-1:0] input word
//   valid_in     data_in carries a valid word this cycle
//   lane1_en     1 = two-lane striping, 0 = lane 0 only
//   lane_out0    [WIDTH-1:0] registered lane-0 word (0 when not valid)
//   valid_out0   lane_out0 valid
//   lane_out1    [WIDTH-1:0] registered lane-1 word (0 when not valid)
//   valid_out1   lane_out1 valid
//   cnt0         [CNT_W-1:0] words sent on lane 0 since reset (wraps)
//   cnt1         [CNT_W-1:0] words sent on lane 1 since reset (wraps)
//   active_lane  lane the next valid word will use (combinational)
// -----------------------------------------------------------------------------
module striping #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             lane1_en,
    output logic [WIDTH-1:0] lane_out0,
    output logic             valid_out0,
    output logic [WIDTH-1:0] lane_out1,
    output logic             valid_out1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             active_lane
);

    // NEXT1: last word went to lane 0 with striping enabled.
    // NEXT0: last word went to lane 1; behaves like IDLE for routing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NEXT1 = 2'd1,
        NEXT0 = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic sel0;
    logic sel1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = IDLE;
        if (valid_in) begin
            case (state)
                NEXT1:   state_nxt = lane1_en ? NEXT0 : IDLE;
                default: state_nxt = lane1_en ? NEXT1 : IDLE;
            endcase
        end
    end

    // Output / routing decode
    always_comb begin
        active_lane = (state == NEXT1) && lane1_en;
        sel1        = valid_in && active_lane;
        sel0        = valid_in && !active_lane;
    end

    // Registered lane outputs and counters. Data is gated by the select so an
    // undriven data_in during idle cycles never reaches the lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_out0  <= '0;
            valid_out0 <= 1'b0;
            lane_out1  <= '0;
            valid_out1 <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            lane_out0  <= sel0 ? data_in : '0;
            valid_out0 <= sel0;
            lane_out1  <= sel1 ? data_in : '0;
            valid_out1 <= sel1;
            if (sel0) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (sel1) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_striping.sv
// -----------------------------------------------------------------------------
// tb_striping
//   Self-checking bench for striping. A small reference model tracks the
//   routing rule: a valid word goes to lane 1 only if the word in the previous
//   cycle was valid, landed on lane 0 while striping was enabled, and striping
//   is still enabled now; otherwise it goes to lane 0.
// -----------------------------------------------------------------------------
module tb_striping;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             lane1_en;
    logic [WIDTH-1:0] lane_out0;
    logic             valid_out0;
    logic [WIDTH-1:0] lane_out1;
    logic             valid_out1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             active_lane;

    int n_tests;
    int n_fail;

    // reference model state
    bit          m_open;
    int          m_cnt0;
    int          m_cnt1;
    logic [31:0] m_out0;
    logic [31:0] m_out1;
    bit          m_vld0;
    bit          m_vld1;

    striping #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .lane1_en   (lane1_en),
        .lane_out0  (lane_out0),
        .valid_out0 (valid_out0),
        .lane_out1  (lane_out1),
        .valid_out1 (valid_out1),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .active_lane(active_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 1'b0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_out0 = '0;
        m_out1 = '0;
        m_vld0 = 1'b0;
        m_vld1 = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".lane_out0"},  64'(lane_out0),  64'(m_out0));
        chk({tag, ".valid_out0"}, 64'(valid_out0), 64'(m_vld0));
        chk({tag, ".lane_out1"},  64'(lane_out1),  64'(m_out1));
        chk({tag, ".valid_out1"}, 64'(valid_out1), 64'(m_vld1));
        chk({tag, ".cnt0"},       64'(cnt0),       64'(m_cnt0));
        chk({tag, ".cnt1"},       64'(cnt1),       64'(m_cnt1));
        chk({tag, ".excl"},       64'(valid_out0 && valid_out1), 64'(0));
    endtask

    // Apply one cycle of stimulus, then check after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic en);
        bit to1;
        valid_in = v;
        data_in  = v ? d : 'x;
        lane1_en = en;
        #1;
        chk({tag, ".active_lane"}, 64'(active_lane), 64'(m_open && en));
        @(posedge clk);
        #1;
        if (v) begin
            to1    = m_open && en;
            m_vld0 = !to1;
            m_vld1 = to1;
            m_out0 = to1 ? 32'd0 : d;
            m_out1 = to1 ? d : 32'd0;
            if (to1) m_cnt1 = (m_cnt1 + 1) % 256;
            else     m_cnt0 = (m_cnt0 + 1) % 256;
            m_open = !to1 && en;
        end else begin
            m_vld0 = 1'b0;
            m_vld1 = 1'b0;
            m_out0 = '0;
            m_out1 = '0;
            m_open = 1'b0;
        end
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_async");
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        valid_in = 1'b0;
        lane1_en = 1'b0;
        data_in  = '0;
        model_reset();
        #12;
        check_outputs("por");
        chk("por.active_lane", 64'(active_lane), 64'(0));
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Burst A0..A3 striped across both lanes
        step("burstA0", 1'b1, 32'hA000_0000, 1'b1);
        step("burstA1", 1'b1, 32'hA000_0001, 1'b1);
        step("burstA2", 1'b1, 32'hA000_0002, 1'b1);
        step("burstA3", 1'b1, 32'hA000_0003, 1'b1);
        chk("burstA.cnt0", 64'(cnt0), 64'(2));
        chk("burstA.cnt1", 64'(cnt1), 64'(2));
        step("burstA.idle", 1'b0, 32'h0, 1'b1);

        // Gap realign
        do_reset();
        step("gapB0", 1'b1, 32'hB000_0000, 1'b1);
        step("gapB1", 1'b1, 32'hB000_0001, 1'b1);
        step("gapB2", 1'b1, 32'hB000_0002, 1'b1);
        step("gap",   1'b0, 32'h0,         1'b1);
        step("gapB3", 1'b1, 32'hB000_0003, 1'b1);
        chk("gapB.cnt0", 64'(cnt0), 64'(3));
        chk("gapB.cnt1", 64'(cnt1), 64'(1));

        // Single lane
        do_reset();
        for (int i = 0; i < 5; i++) step("single", 1'b1, 32'h5000_0000 + i, 1'b0);
        chk("single.cnt0", 64'(cnt0), 64'(5));
        chk("single.cnt1", 64'(cnt1), 64'(0));

        // Mode switch
        do_reset();
        step("modeC0", 1'b1, 32'hC000_0000, 1'b1);
        step("modeC1", 1'b1, 32'hC000_0001, 1'b0);
        step("modeC2", 1'b1, 32'hC000_0002, 1'b1);
        step("modeC3", 1'b1, 32'hC000_0003, 1'b1);
        chk("modeC3.valid_out1", 64'(valid_out1), 64'(1));

        // Counter wrap
        do_reset();
        for (int i = 0; i < 512; i++) step("wrap", 1'b1, $urandom, 1'b1);
        chk("wrap.cnt0_end", 64'(cnt0), 64'(0));
        chk("wrap.cnt1_end", 64'(cnt1), 64'(0));

        // Async reset mid-burst, then D0 lands on lane 0
        step("rstmid0", 1'b1, 32'h1111_0000, 1'b1);
        valid_in = 1'b1;
        data_in  = 32'h1111_0001;
        lane1_en = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rstmid");
        #2;
        reset = 1'b0;
        step("rstD0", 1'b1, 32'hD000_0000, 1'b1);
        chk("rstD0.cnt0", 64'(cnt0), 64'(1));
        chk("rstD0.valid_out0", 64'(valid_out0), 64'(1));

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/striping.md
STRIPING -- requirements
Module: striping

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of data_in and of each lane output.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-lane word counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  serial word stream to be striped.
REQ-006 SHALL have port valid_in  input  1  data_in carries a valid word this cycle.
REQ-007 SHALL have port lane1_en  input  1  1 = two-lane striping, 0 = all traffic on lane 0.
REQ-008 SHALL have port lane_out0  output  WIDTH  registered lane-0 word.
REQ-009 SHALL have port valid_out0  output  1  lane_out0 valid.
REQ-010 SHALL have port lane_out1  output  WIDTH  registered lane-1 word.
REQ-011 SHALL have port valid_out1  output  1  lane_out1 valid.
REQ-012 SHALL have port cnt0  output  CNT_W  words sent on lane 0 since reset.
REQ-013 SHALL have port cnt1  output  CNT_W  words sent on lane 1 since reset.
REQ-014 SHALL have port active_lane  output  1  lane that the next valid word will use.

Function
REQ-015 SHALL implement an FSM with states IDLE, NEXT1 (last word on lane 0) and NEXT0 (last word on lane 1).
REQ-016 SHALL, in IDLE or NEXT0 with valid_in=1, route the word to lane 0 and move to NEXT1 if lane1_en=1, otherwise to IDLE.
REQ-017 SHALL, in NEXT1 with valid_in=1 and lane1_en=1, route the word to lane 1 and move to NEXT0.
REQ-018 SHALL, in NEXT1 with valid_in=1 and lane1_en=0, route the word to lane 0 and move to IDLE.
REQ-019 SHALL, in any state with valid_in=0, move to IDLE, so the next valid word after any gap goes to lane 0.
REQ-020 SHALL register lane outputs with 1-cycle latency: a word sampled at edge k is on the selected lane_outX with valid_outX=1 from edge k until edge k+1.
REQ-021 SHALL drive the non-selected lane to data 0 and valid 0 in the same cycle, and drive both lanes to 0 after an edge where valid_in=0.
REQ-022 SHALL never assert valid_out0 and valid_out1 in the same cycle.
REQ-023 SHALL drive active_lane combinationally: 1 only when state=NEXT1 and lane1_en=1, else 0.
REQ-024 SHALL increment cnt0 or cnt1 by 1 on each edge that routes a word to that lane; the counters wrap from 2^CNT_W-1 to 0 without a flag.
REQ-025 SHALL sample lane1_en each cycle; a change takes effect on the next accepted word with no word loss or duplication.
REQ-026 SHALL ignore data_in when valid_in=0; X on data_in SHALL NOT propagate to outputs.

Reset
REQ-027 SHALL, while reset=1, immediately (independent of clk) force state=IDLE, lane_out0=lane_out1=0, valid_out0=valid_out1=0, cnt0=cnt1=0.
REQ-028 SHALL, on reset asserted mid-burst, discard the in-flight word; after release the first valid word SHALL go to lane 0.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-030 Burst: lane1_en=1, valid_in=1 for words A0,A1,A2,A3 on consecutive edges -> lane0 A0,-,A2,- and lane1 -,A1,-,A3, each one cycle late; then cnt0=2, cnt1=2.
REQ-031 Gap realign: words B0,B1,B2 then valid_in=0 for 1 cycle, then B3 -> B0 lane0, B1 lane1, B2 lane0, idle cycle with both valids 0, B3 lane0; final cnt0=3, cnt1=1.
REQ-032 Single-lane: lane1_en=0, 5 consecutive words -> all 5 on lane0 back-to-back, valid_out1 stays 0, cnt0=5, cnt1=0, active_lane=0 throughout.
REQ-033 Mode switch: lane1_en=1, word C0 to lane0, then lane1_en=0 before C1 -> C1 on lane0, state IDLE; re-enable before C2 -> C2 on lane0, C3 on lane1.
REQ-034 Wrap: CNT_W=8, 512 consecutive words with lane1_en=1 -> cnt0 and cnt1 each pass 255 to 0 and end at 0.
REQ-035 Async reset: assert reset between edges mid-burst -> all outputs 0 before next edge; after release first word D0 appears on lane0, cnt0=1.
